period_meter: RTL and testbench

- Measures an external slow square wave (`sig_in`), typically a divided clock from the clock-divider chain, in units of the system clock.
- Reports the period (rising edge to rising edge) and the high time, both in `clk` cycles.
- Sits beside the clock-generation logic as its self-check and frequency monitor.
- Supports single-shot or continuous measurement, with overflow detection for stalled inputs.

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/period_meter_edge_sync.sv | 39 +++
 rtl/period_meter.sv | 152 +++++++++++++++
 tb/tb_period_meter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: state encoding and default counter width.
package period_meter_pkg;

  localparam int PM_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_WAIT = 2'd1,
    PM_MEAS = 2'd2
  } pm_state_e;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchronizer for a slow asynchronous level, with registered-history edge strobes.
module edge_sync
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, single-shot or continuous,
// with a sticky overflow flag for stalled inputs.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = PM_CNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 busy,
  output logic                 overflow
);

  localparam int              WU_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);

  pm_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                 fell_q, fell_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic [WU_W-1:0]      warm_q, warm_d;

  logic s_level;
  logic s_rise;
  logic s_fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (sig_in),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    fell_d   = fell_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    if (warm_q != '0) begin
      warm_d = warm_q - WU_W'(1);
    end else begin
      warm_d = warm_q;
    end

    case (state_q)
      PM_IDLE: begin
        // Warmup masks edges produced by the synchronizer coming out of reset.
        if (start && (warm_q == '0)) begin
          ovf_d   = 1'b0;
          state_d = PM_WAIT;
        end else begin
          state_d = PM_IDLE;
        end
      end
      PM_WAIT: begin
        if (s_rise) begin
          cnt_d   = CNT_WIDTH'(1);
          hcnt_d  = CNT_WIDTH'(1);
          fell_d  = 1'b0;
          state_d = PM_MEAS;
        end else begin
          state_d = PM_WAIT;
        end
      end
      PM_MEAS: begin
        if (s_rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          if (continuous) begin
            cnt_d  = CNT_WIDTH'(1);
            hcnt_d = CNT_WIDTH'(1);
            fell_d = 1'b0;
          end else begin
            state_d = PM_IDLE;
          end
        end else if (&cnt_q) begin
          ovf_d   = 1'b1;
          state_d = PM_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (s_fall) begin
            fell_d = 1'b1;
          end else if (!fell_q && s_level) begin
            hcnt_d = hcnt_q + CNT_WIDTH'(1);
          end else begin
            hcnt_d = hcnt_q;
          end
        end
      end
      default: begin
        state_d = PM_IDLE;
      end
    endcase

    busy_d = (warm_d != '0) || (state_d != PM_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PM_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      fell_q   <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b1;
      warm_q   <= WU_INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      fell_q   <= fell_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      warm_q   <= warm_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: scoreboard of expected results filled as waveforms are driven.
module tb_period_meter;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, sig_in, start, continuous;
  logic [15:0] period, high_time;
  logic        valid, busy, overflow;

  logic        sig2, start2, cont2;
  logic [3:0]  period2, high2;
  logic        valid2, busy2, ovf2;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   valid_cnt = 0, valid2_cnt = 0;
  int   exp_left = 0, prev_hi = 0, prev_lo = 0, base = 0;
  bit   have_prev = 1'b0;

  always #5 clk = ~clk;

  period_meter u_dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .period(period), .high_time(high_time), .valid(valid), .busy(busy), .overflow(overflow)
  );

  period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) u_ovf (
    .clk(clk), .rst(rst), .sig_in(sig2), .start(start2), .continuous(cont2),
    .period(period2), .high_time(high2), .valid(valid2), .busy(busy2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Drive n periods; each rise after the first closes a period and queues its expected result.
  task automatic wave(input int hi, input int lo, input int n, input int start_cyc);
    int c;
    c = 0;
    for (int p = 0; p < n; p++) begin
      if (have_prev && exp_left > 0) begin
        sb.push_back('{per: 16'(prev_hi + prev_lo), hi: 16'(prev_hi)});
        exp_left--;
      end
      have_prev = 1'b1;
      prev_hi   = hi;
      prev_lo   = lo;
      for (int k = 0; k < hi + lo; k++) begin
        sig_in = (k < hi);
        start  = (c == start_cyc);
        c++;
        tick(1);
      end
    end
    start = 1'b0;
  endtask

  // Output monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("period", 32'(period), 32'(mon_e.per));
        chk("high_time", 32'(high_time), 32'(mon_e.hi));
      end
    end
    if (valid2 === 1'b1) valid2_cnt++;
  end

  initial begin
    rst = 1'b1; sig_in = 1'b0; start = 1'b0; continuous = 1'b0;
    sig2 = 1'b0; start2 = 1'b0; cont2 = 1'b0;
    tick(2);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_time), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Start during warmup is dropped
    rst = 1'b0; start = 1'b1;
    tick(2);
    start = 1'b0;
    chk("warm_busy", 32'(busy), 32'd1);
    tick(1);
    chk("warm_done_busy", 32'(busy), 32'd0);
    tick(3);
    chk("warm_start_dropped", 32'(busy), 32'd0);

    // Single-shot, divide-by-4
    continuous = 1'b0; have_prev = 1'b0; exp_left = 1; base = valid_cnt;
    arm();
    wave(2, 2, 3, -1);
    tick(8);
    chk("t1_valid_count", 32'(valid_cnt - base), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Start while measuring is ignored
    have_prev = 1'b0; exp_left = 1; base = valid_cnt;
    arm();
    wave(2, 2, 3, 3);
    tick(8);
    chk("t4_valid_count", 32'(valid_cnt - base), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Continuous mode with a rate change, then stop
    continuous = 1'b1; have_prev = 1'b0; exp_left = 7; base = valid_cnt;
    arm();
    wave(3, 7, 4, -1);
    wave(3, 3, 4, -1);
    continuous = 1'b0; exp_left = 1;
    wave(3, 3, 1, -1);
    tick(10);
    chk("t2_valid_count", 32'(valid_cnt - base), 32'd8);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a measurement
    continuous = 1'b1; have_prev = 1'b0; exp_left = 0;
    arm();
    wave(3, 7, 1, -1);
    chk("t5_busy_meas", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t5_period", 32'(period), 32'd0);
    chk("t5_high", 32'(high_time), 32'd0);
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_busy_warm", 32'(busy), 32'd1);
    rst = 1'b0; base = valid_cnt;
    wave(3, 7, 3, -1);
    tick(5);
    chk("t5_no_stale_valid", 32'(valid_cnt - base), 32'd0);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    // Overflow on the 4-bit instance, after one good result
    start2 = 1'b1; tick(1); start2 = 1'b0;
    sig2 = 1'b1; tick(2);
    sig2 = 1'b0; tick(4);
    sig2 = 1'b1; tick(2);
    sig2 = 1'b0; tick(6);
    chk("t3_pre_period", 32'(period2), 32'd6);
    chk("t3_pre_high", 32'(high2), 32'd2);
    chk("t3_pre_valid_count", 32'(valid2_cnt), 32'd1);
    chk("t3_pre_busy", 32'(busy2), 32'd0);
    start2 = 1'b1; tick(1); start2 = 1'b0;
    sig2 = 1'b1;
    tick(10);
    chk("t3_mid_overflow", 32'(ovf2), 32'd0);
    chk("t3_mid_busy", 32'(busy2), 32'd1);
    tick(15);
    chk("t3_overflow", 32'(ovf2), 32'd1);
    chk("t3_busy", 32'(busy2), 32'd0);
    chk("t3_period_kept", 32'(period2), 32'd6);
    chk("t3_high_kept", 32'(high2), 32'd2);
    chk("t3_no_valid", 32'(valid2_cnt), 32'd1);
    start2 = 1'b1; tick(1); start2 = 1'b0;
    chk("t3_ovf_cleared", 32'(ovf2), 32'd0);
    chk("t3_rearmed_busy", 32'(busy2), 32'd1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
